tok_loader: RTL and testbench

//  UART program loader: writer for the TOK program RAM that the core reads. Owns the UART

---
 rtl/tok_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_tok_loader.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tok_loader.sv
// tok_loader - UART program loader for the TOK core's program RAM.
//
// Takes the UART after reset and holds the core in reset while it receives a
// framed program image: SOH, LEN, LEN data bytes, SUM.
//  - LEN = 0 means 256 data bytes.
//  - The frame is good when the 8-bit sum of LEN, the data bytes and SUM is 0.
// Each data byte is written to program RAM exactly once, at consecutive
// addresses starting from 0. The loader then answers the sender:
//  - ACK: the core is released and the UART is handed over.
//  - NAK: the loader goes back to hunting for SOH with the core still held.
// A frame that stalls for TIMEOUT_CYCLES is also NAKed.
//
// Ports
//  clk            clock
//  reset          asynchronous, active-low reset
//  uart_rx_valid  UART has a received byte
//  uart_rx_data   received byte
//  uart_rd        consume the received byte (combinational)
//  uart_tx_busy   UART transmitter busy
//  uart_wr        one-cycle transmit strobe
//  uart_tx_data   byte to transmit
//  load_req       pulse in RUN: take the UART back and wait for a new image
//  ram_waddr      program RAM write address
//  ram_din        program RAM write data
//  ram_we         program RAM write enable
//  core_reset_n   TOK core reset, active-low
//  loading        1 while the loader owns the UART
//  err_count      bad frames plus timeouts, saturating at 8'hFF
module tok_loader #(
  parameter logic [7:0]  SOH_BYTE       = 8'h01,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15,
  parameter int unsigned TIMEOUT_CYCLES = 1200000,
  parameter int unsigned TMO_W          = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx_valid,
  input  logic [7:0] uart_rx_data,
  output logic       uart_rd,
  input  logic       uart_tx_busy,
  output logic       uart_wr,
  output logic [7:0] uart_tx_data,
  input  logic       load_req,
  output logic [7:0] ram_waddr,
  output logic [7:0] ram_din,
  output logic       ram_we,
  output logic       core_reset_n,
  output logic       loading,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    ST_WAIT_SOH  = 3'd0,
    ST_GET_LEN   = 3'd1,
    ST_GET_DATA  = 3'd2,
    ST_GET_SUM   = 3'd3,
    ST_SEND_RESP = 3'd4,
    ST_RUN       = 3'd5
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ZERO  = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  // Data bytes still expected. Nine bits so that LEN = 0 can be held as 256.
  logic [8:0]        count_r;
  logic [7:0]        sum_r;
  logic [7:0]        addr_r;
  logic [TMO_W-1:0]  timer_r;
  logic              ack_r;
  logic              rx_take_s;
  logic              timeout_s;

  // A frame is good when its running sum plus the SUM byte is 0 modulo 256.
  function automatic logic frame_sum_ok(input logic [7:0] sum, input logic [7:0] b);
    logic [7:0] total;
    total = sum + b;
    return (total == 8'h00);
  endfunction

  // Saturating increment: the error counter sticks at 8'hFF.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : (v + 8'h01);
  endfunction

  // Decide whether the UART byte is consumed this cycle. The byte is only consumed in the receive states.
  always_comb begin
    rx_take_s = 1'b0;
    case (state_r)
      ST_WAIT_SOH, ST_GET_LEN, ST_GET_DATA, ST_GET_SUM: rx_take_s = uart_rx_valid;
      default:                                          rx_take_s = 1'b0;
    endcase
  end

  assign uart_rd   = rx_take_s;
  assign timeout_s = (timer_r == TMO_LAST);

  // Loader state machine, frame bookkeeping and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_WAIT_SOH;
      count_r      <= 9'd0;
      sum_r        <= 8'h00;
      addr_r       <= 8'h00;
      timer_r      <= TMO_ZERO;
      ack_r        <= 1'b0;
      uart_wr      <= 1'b0;
      uart_tx_data <= 8'h00;
      ram_waddr    <= 8'h00;
      ram_din      <= 8'h00;
      ram_we       <= 1'b0;
      core_reset_n <= 1'b0;
      loading      <= 1'b1;
      err_count    <= 8'h00;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      ram_we  <= 1'b0;
      uart_wr <= 1'b0;
      case (state_r)
        ST_WAIT_SOH: begin
          // No timeout while hunting for SOH. The timer is held clear so a frame starts from 0.
          timer_r <= TMO_ZERO;
          if (rx_take_s && (uart_rx_data == SOH_BYTE)) begin
            state_r <= ST_GET_LEN;
          end else begin
            state_r <= ST_WAIT_SOH;
          end
        end

        ST_GET_LEN: begin
          if (rx_take_s) begin
            count_r <= (uart_rx_data == 8'h00) ? 9'd256 : {1'b0, uart_rx_data};
            sum_r   <= uart_rx_data;
            addr_r  <= 8'h00;
            timer_r <= TMO_ZERO;
            state_r <= ST_GET_DATA;
          end else if (timeout_s) begin
            ack_r        <= 1'b0;
            uart_tx_data <= NAK_BYTE;
            err_count    <= sat_inc8(err_count);
            state_r      <= ST_SEND_RESP;
          end else begin
            timer_r <= timer_r + TMO_ONE;
          end
        end

        ST_GET_DATA: begin
          // Every byte here is payload, including bytes equal to SOH.
          if (rx_take_s) begin
            ram_we    <= 1'b1;
            ram_waddr <= addr_r;
            ram_din   <= uart_rx_data;
            addr_r    <= addr_r + 8'h01;
            sum_r     <= sum_r + uart_rx_data;
            count_r   <= count_r - 9'd1;
            timer_r   <= TMO_ZERO;
            if (count_r == 9'd1) begin
              state_r <= ST_GET_SUM;
            end else begin
              state_r <= ST_GET_DATA;
            end
          end else if (timeout_s) begin
            ack_r        <= 1'b0;
            uart_tx_data <= NAK_BYTE;
            err_count    <= sat_inc8(err_count);
            state_r      <= ST_SEND_RESP;
          end else begin
            timer_r <= timer_r + TMO_ONE;
          end
        end

        ST_GET_SUM: begin
          if (rx_take_s) begin
            timer_r <= TMO_ZERO;
            if (frame_sum_ok(sum_r, uart_rx_data)) begin
              ack_r        <= 1'b1;
              uart_tx_data <= ACK_BYTE;
            end else begin
              ack_r        <= 1'b0;
              uart_tx_data <= NAK_BYTE;
              err_count    <= sat_inc8(err_count);
            end
            state_r <= ST_SEND_RESP;
          end else if (timeout_s) begin
            ack_r        <= 1'b0;
            uart_tx_data <= NAK_BYTE;
            err_count    <= sat_inc8(err_count);
            state_r      <= ST_SEND_RESP;
          end else begin
            timer_r <= timer_r + TMO_ONE;
          end
        end

        ST_SEND_RESP: begin
          // uart_tx_data already holds the response and stays put until the strobe.
          if (!uart_tx_busy) begin
            uart_wr <= 1'b1;
            state_r <= ack_r ? ST_RUN : ST_WAIT_SOH;
          end else begin
            state_r <= ST_SEND_RESP;
          end
        end

        ST_RUN: begin
          // Release happens one cycle after the ACK strobe, because the release is registered here in RUN.
          if (load_req) begin
            core_reset_n <= 1'b0;
            loading      <= 1'b1;
            state_r      <= ST_WAIT_SOH;
          end else begin
            core_reset_n <= 1'b1;
            loading      <= 1'b0;
            state_r      <= ST_RUN;
          end
        end

        default: begin
          state_r <= ST_WAIT_SOH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tok_loader.sv
// tb_tok_loader - directed self-checking bench for tok_loader.
// A short timeout is used so that stalled frames resolve quickly.
module tb_tok_loader;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rd;
  logic       uart_tx_busy;
  logic       uart_wr;
  logic [7:0] uart_tx_data;
  logic       load_req;
  logic [7:0] ram_waddr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic       core_reset_n;
  logic       loading;
  logic [7:0] err_count;

  int checks   = 0;
  int failures = 0;

  // Shadow of the program RAM plus write/transmit observers.
  logic [7:0] mem [0:255];
  int         wr_count = 0;
  int         tx_count = 0;
  logic [7:0] tx_last  = 8'h00;

  always #5 clk = ~clk;

  tok_loader #(
    .SOH_BYTE       (8'h01),
    .ACK_BYTE       (8'h06),
    .NAK_BYTE       (8'h15),
    .TIMEOUT_CYCLES (TMO),
    .TMO_W          (24)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_rd       (uart_rd),
    .uart_tx_busy  (uart_tx_busy),
    .uart_wr       (uart_wr),
    .uart_tx_data  (uart_tx_data),
    .load_req      (load_req),
    .ram_waddr     (ram_waddr),
    .ram_din       (ram_din),
    .ram_we        (ram_we),
    .core_reset_n  (core_reset_n),
    .loading       (loading),
    .err_count     (err_count)
  );

  // Observe RAM writes and transmit strobes mid-cycle.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      mem[ram_waddr] = ram_din;
      wr_count       = wr_count + 1;
    end
    if (uart_wr === 1'b1) begin
      tx_count = tx_count + 1;
      tx_last  = uart_tx_data;
    end
  end

  task automatic do_reset();
    reset         = 1'b0;
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
    uart_tx_busy  = 1'b0;
    load_req      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    #1;
    n = 0;
    while (uart_rd !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_byte_accept: byte %02h never consumed (uart_rd=%b)", b, uart_rd);
    end
    @(posedge clk);
    #1;
    uart_rx_valid = 1'b0;
  endtask

  task automatic send_case1();
    send_byte(8'h01); send_byte(8'h03); send_byte(8'h41);
    send_byte(8'h42); send_byte(8'h43); send_byte(8'h37);
  endtask

  task automatic wait_tx(input int base, input int limit, output logic got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      #1;
      if (tx_count != base) got = 1'b1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (uart_wr !== 1'b0 || uart_tx_data !== 8'h00 || ram_we !== 1'b0 || ram_waddr !== 8'h00 ||
        ram_din !== 8'h00 || core_reset_n !== 1'b0 || loading !== 1'b1 || err_count !== 8'h00) begin
      failures++;
      $display("FAIL %s: wr=%b txd=%02h we=%b wa=%02h din=%02h crn=%b ld=%b err=%02h, required 0 00 0 00 00 0 1 00",
               tag, uart_wr, uart_tx_data, ram_we, ram_waddr, ram_din, core_reset_n, loading, err_count);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_values("reset_values");
    checks++;
    uart_rx_valid = 1'b1;
    #1;
    if (uart_rd !== 1'b1) begin
      failures++;
      $display("FAIL rd_in_wait_soh: uart_rd=%b, required 1", uart_rd);
    end
    uart_rx_valid = 1'b0;
  endtask

  task automatic test_ack_frame();
    int   wbase, tbase;
    logic got;
    do_reset();
    wbase = wr_count;
    tbase = tx_count;
    send_case1();
    wait_tx(tbase, 50, got);
    checks++;
    if (!got || tx_last !== 8'h06) begin
      failures++;
      $display("FAIL ack_tx: got=%b byte=%02h, required 06", got, tx_last);
    end
    checks++;
    if (core_reset_n !== 1'b0) begin
      failures++;
      $display("FAIL ack_release_early: core_reset_n=%b in strobe cycle, required 0", core_reset_n);
    end
    checks++;
    if (wr_count - wbase != 3 || mem[0] !== 8'h41 || mem[1] !== 8'h42 || mem[2] !== 8'h43) begin
      failures++;
      $display("FAIL ack_writes: n=%0d [0]=%02h [1]=%02h [2]=%02h, required 3 41 42 43",
               wr_count - wbase, mem[0], mem[1], mem[2]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (core_reset_n !== 1'b1 || loading !== 1'b0 || err_count !== 8'h00) begin
      failures++;
      $display("FAIL ack_run: crn=%b loading=%b err=%02h, required 1 0 00", core_reset_n, loading, err_count);
    end
  endtask

  task automatic test_nak_frame();
    int   wbase, tbase;
    logic got;
    do_reset();
    wbase = wr_count;
    tbase = tx_count;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h00);
    wait_tx(tbase, 50, got);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (!got || tx_last !== 8'h15) begin
      failures++;
      $display("FAIL nak_tx: got=%b byte=%02h, required 15", got, tx_last);
    end
    checks++;
    if (wr_count - wbase != 2 || mem[0] !== 8'hAA || mem[1] !== 8'hBB) begin
      failures++;
      $display("FAIL nak_writes: n=%0d [0]=%02h [1]=%02h, required 2 AA BB", wr_count - wbase, mem[0], mem[1]);
    end
    checks++;
    if (core_reset_n !== 1'b0 || loading !== 1'b1 || err_count !== 8'h01) begin
      failures++;
      $display("FAIL nak_state: crn=%b loading=%b err=%02h, required 0 1 01", core_reset_n, loading, err_count);
    end
    tbase = tx_count;
    send_case1();
    wait_tx(tbase, 50, got);
    checks++;
    if (!got || tx_last !== 8'h06 || err_count !== 8'h01) begin
      failures++;
      $display("FAIL nak_then_ack: got=%b byte=%02h err=%02h, required 06 01", got, tx_last, err_count);
    end
  endtask

  task automatic test_resync();
    int   wbase, tbase;
    logic got;
    do_reset();
    wbase = wr_count;
    tbase = tx_count;
    send_byte(8'h55);
    send_byte(8'hFF);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (wr_count != wbase || tx_count != tbase) begin
      failures++;
      $display("FAIL resync_junk: writes=%0d tx=%0d, required 0 0", wr_count - wbase, tx_count - tbase);
    end
    send_case1();
    wait_tx(tbase, 50, got);
    checks++;
    if (!got || tx_last !== 8'h06 || wr_count - wbase != 3) begin
      failures++;
      $display("FAIL resync_ack: got=%b byte=%02h writes=%0d, required 06 3", got, tx_last, wr_count - wbase);
    end
  endtask

  task automatic test_len256();
    int   wbase, tbase, bad;
    logic got;
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    wbase = wr_count;
    tbase = tx_count;
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      send_byte(b);
    end
    send_byte(8'h80);
    wait_tx(tbase, 50, got);
    checks++;
    if (!got || tx_last !== 8'h06) begin
      failures++;
      $display("FAIL len256_tx: got=%b byte=%02h, required 06", got, tx_last);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      if (mem[i] !== b) bad++;
    end
    checks++;
    if (wr_count - wbase != 256 || bad != 0 || mem[255] !== 8'hFF) begin
      failures++;
      $display("FAIL len256_writes: n=%0d bad=%0d [FF]=%02h, required 256 0 FF", wr_count - wbase, bad, mem[255]);
    end
  endtask

  task automatic test_timeout_busy();
    int   tbase, bad;
    logic got;
    do_reset();
    uart_tx_busy = 1'b1;
    tbase = tx_count;
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h11);
    repeat (TMO) @(negedge clk);
    #1;
    checks++;
    if (uart_tx_data !== 8'h00 || err_count !== 8'h00) begin
      failures++;
      $display("FAIL timeout_early: txd=%02h err=%02h, required 00 00", uart_tx_data, err_count);
    end
    @(negedge clk);
    #1;
    checks++;
    if (uart_tx_data !== 8'h15 || err_count !== 8'h01) begin
      failures++;
      $display("FAIL timeout_nak: txd=%02h err=%02h, required 15 01", uart_tx_data, err_count);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (uart_wr !== 1'b0 || uart_tx_data !== 8'h15) bad++;
    end
    checks++;
    if (bad != 0 || tx_count != tbase) begin
      failures++;
      $display("FAIL busy_hold: bad_cycles=%0d strobes=%0d, required 0 0", bad, tx_count - tbase);
    end
    uart_tx_busy = 1'b0;
    wait_tx(tbase, 10, got);
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (!got || tx_count - tbase != 1 || tx_last !== 8'h15) begin
      failures++;
      $display("FAIL busy_strobe: strobes=%0d byte=%02h, required 1 15", tx_count - tbase, tx_last);
    end
    checks++;
    if (core_reset_n !== 1'b0 || loading !== 1'b1) begin
      failures++;
      $display("FAIL timeout_held: crn=%b loading=%b, required 0 1", core_reset_n, loading);
    end
  endtask

  task automatic test_load_req_and_abort();
    int   tbase;
    logic got;
    do_reset();
    tbase = tx_count;
    send_case1();
    wait_tx(tbase, 50, got);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (core_reset_n !== 1'b1 || loading !== 1'b0) begin
      failures++;
      $display("FAIL run_state: crn=%b loading=%b, required 1 0", core_reset_n, loading);
    end
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h01;
    load_req      = 1'b1;
    #1;
    checks++;
    if (uart_rd !== 1'b0) begin
      failures++;
      $display("FAIL run_rd: uart_rd=%b with load_req, required 0", uart_rd);
    end
    @(posedge clk);
    #1;
    load_req      = 1'b0;
    uart_rx_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (core_reset_n !== 1'b0 || loading !== 1'b1) begin
      failures++;
      $display("FAIL load_req_rearm: crn=%b loading=%b, required 0 1", core_reset_n, loading);
    end
    mem[0] = 8'hEE;
    mem[1] = 8'hEE;
    send_byte(8'h01); send_byte(8'h04); send_byte(8'h10); send_byte(8'h20);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_values("abort_reset_values");
    checks++;
    if (mem[0] !== 8'h10 || mem[1] !== 8'h20) begin
      failures++;
      $display("FAIL abort_ram_kept: [0]=%02h [1]=%02h, required 10 20", mem[0], mem[1]);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ack_frame();
    test_nak_frame();
    test_resync();
    test_len256();
    test_timeout_busy();
    test_load_req_and_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
